// File: rtl/alu_mem_engine_pkg.sv
// rtl/alu_mem_engine_pkg.sv - opcode/state types and opcode legality helper for the memory-backed ALU
package alu_mem_pkg;

   typedef enum logic [7:0] {
      OP_ADD = 8'h05,
      OP_MUL = 8'h06,
      OP_SUB = 8'h07,
      OP_AND = 8'h08,
      OP_OR  = 8'h09,
      OP_XOR = 8'h0A
   } opcode_e;

   typedef enum logic [2:0] {
      IDLE,
      RD_A,
      RD_B,
      EXEC,
      WR
   } state_e;

   function automatic logic is_legal(input logic [7:0] op);
      return (op >= 8'h05) && (op <= 8'h0A);
   endfunction

endpackage

// File: rtl/alu_mem_engine_if.sv
// rtl/alu_mem_engine_if.sv - command handshake and host memory port bundle
interface alu_mem_engine_if #(
   parameter int AW = 8,
   parameter int DW = 16
) ();

   logic          start;
   logic [7:0]    opcode;
   logic [AW-1:0] src_a;
   logic [AW-1:0] src_b;
   logic [AW-1:0] dst;
   logic          ready;
   logic          done;
   logic          err;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic [DW-1:0] host_rdata;

   modport master (
      output start, opcode, src_a, src_b, dst,
      output host_we, host_addr, host_wdata,
      input  ready, done, err, host_rdata
   );

   modport slave (
      input  start, opcode, src_a, src_b, dst,
      input  host_we, host_addr, host_wdata,
      output ready, done, err, host_rdata
   );

endinterface

// File: rtl/alu_mem_engine_array.sv
// rtl/alu_mem_engine_array.sv - word memory with two asynchronous read ports and one synchronous write port
module alu_mem_array #(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr_eng,
   output logic [DW-1:0] rdata_eng,
   input  logic [AW-1:0] raddr_host,
   output logic [DW-1:0] rdata_host
);

   // Contents are deliberately left unreset so a reset mid-operation preserves memory.
   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_eng  = mem[raddr_eng];
   assign rdata_host = mem[raddr_host];

endmodule

// File: rtl/alu_mem_engine.sv
// rtl/alu_mem_engine.sv - sequences operand reads, ALU evaluation and result write-back into the memory array
module alu_mem_engine
   import alu_mem_pkg::*;
#(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_mem_engine_if.slave bus
);

   state_e        state;
   logic [7:0]    opcode_q;
   logic [AW-1:0] src_a_q;
   logic [AW-1:0] src_b_q;
   logic [AW-1:0] dst_q;
   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;
   logic [DW-1:0] res;
   logic [DW-1:0] alu_res;
   logic          done_q;
   logic          err_q;

   logic [AW-1:0] eng_raddr;
   logic [DW-1:0] eng_rdata;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;

   assign bus.ready = (state == IDLE);
   assign bus.done  = done_q;
   assign bus.err   = err_q;

   assign eng_raddr = (state == RD_B) ? src_b_q : src_a_q;

   // Engine owns the write port only in WR; host writes are honoured only while idle.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = bus.host_addr;
      mem_wdata = bus.host_wdata;
      if (state == WR) begin
         mem_we    = 1'b1;
         mem_waddr = dst_q;
         mem_wdata = res;
      end else if (state == IDLE && bus.host_we) begin
         mem_we    = 1'b1;
      end
   end

   alu_mem_array #(
      .AW(AW),
      .DW(DW)
   ) u_array (
      .clk        (clk),
      .we         (mem_we),
      .waddr      (mem_waddr),
      .wdata      (mem_wdata),
      .raddr_eng  (eng_raddr),
      .rdata_eng  (eng_rdata),
      .raddr_host (bus.host_addr),
      .rdata_host (bus.host_rdata)
   );

   always_comb begin
      alu_res = '0;
      case (opcode_q)
         OP_ADD:  alu_res = op_a + op_b;
         OP_MUL:  alu_res = op_a * op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         opcode_q <= '0;
         src_a_q  <= '0;
         src_b_q  <= '0;
         dst_q    <= '0;
         op_a     <= '0;
         op_b     <= '0;
         res      <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  opcode_q <= bus.opcode;
                  src_a_q  <= bus.src_a;
                  src_b_q  <= bus.src_b;
                  dst_q    <= bus.dst;
                  state    <= RD_A;
               end
            end
            RD_A: begin
               op_a  <= eng_rdata;
               state <= RD_B;
            end
            RD_B: begin
               op_b  <= eng_rdata;
               state <= EXEC;
            end
            EXEC: begin
               res <= alu_res;
               if (!is_legal(opcode_q)) begin
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
                  state  <= IDLE;
               end else begin
                  state <= WR;
               end
            end
            WR: begin
               done_q <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mem_engine.sv
// tb/tb_alu_mem_engine.sv - directed self-checking bench for alu_mem_engine
module tb_alu_mem_engine;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   alu_mem_engine_if #(.AW(8), .DW(16)) bus ();

   alu_mem_engine #(.AW(8), .DW(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic peek(input logic [7:0] addr, output logic [15:0] data);
      bus.host_addr = addr;
      #1;
      data = bus.host_rdata;
   endtask

   task automatic host_wr(input logic [7:0] addr, input logic [15:0] data);
      @(negedge clk);
      bus.host_we    = 1'b1;
      bus.host_addr  = addr;
      bus.host_wdata = data;
      @(negedge clk);
      bus.host_we    = 1'b0;
   endtask

   // Called at a negedge; returns cycles until done is seen (99 if never) and err at that point.
   task automatic run_op(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] d, output int lat, output logic e);
      bus.start  = 1'b1;
      bus.opcode = op;
      bus.src_a  = a;
      bus.src_b  = b;
      bus.dst    = d;
      lat = 99;
      e   = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 1) begin
            bus.start   = 1'b0;
            bus.host_we = 1'b0;
         end
         if (bus.done) begin
            lat = n;
            e   = bus.err;
            break;
         end
      end
   endtask

   logic [15:0] rd;
   int          lat;
   logic        e;
   int          extra;

   initial begin
      bus.start      = 1'b0;
      bus.opcode     = 8'h00;
      bus.src_a      = 8'h00;
      bus.src_b      = 8'h00;
      bus.dst        = 8'h00;
      bus.host_we    = 1'b0;
      bus.host_addr  = 8'h00;
      bus.host_wdata = 16'h0000;

      repeat (2) @(negedge clk);
      check("reset_ready", 32'(bus.ready), 32'd1);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_err", 32'(bus.err), 32'd0);
      rst_n = 1'b1;

      // ADD with done latency
      host_wr(8'd1, 16'h0003);
      host_wr(8'd2, 16'h0004);
      run_op(8'h05, 8'd1, 8'd2, 8'd3, lat, e);
      check("add_latency", 32'(lat), 32'd5);
      check("add_err", 32'(e), 32'd0);
      check("add_ready", 32'(bus.ready), 32'd1);
      peek(8'd3, rd); check("add_result", 32'(rd), 32'h0007);
      peek(8'd1, rd); check("add_src_a_kept", 32'(rd), 32'h0003);
      peek(8'd2, rd); check("add_src_b_kept", 32'(rd), 32'h0004);

      // MUL and SUB wrap-around
      host_wr(8'd4, 16'hFFFF);
      host_wr(8'd5, 16'h0002);
      run_op(8'h06, 8'd4, 8'd5, 8'd6, lat, e);
      peek(8'd6, rd); check("mul_wrap", 32'(rd), 32'hFFFE);
      @(negedge clk);
      run_op(8'h07, 8'd5, 8'd4, 8'd6, lat, e);
      peek(8'd6, rd); check("sub_wrap", 32'(rd), 32'h0003);

      // AND / OR
      host_wr(8'd14, 16'h0FF0);
      host_wr(8'd15, 16'hA5A5);
      run_op(8'h08, 8'd14, 8'd15, 8'd21, lat, e);
      peek(8'd21, rd); check("and_result", 32'(rd), 32'h05A0);
      @(negedge clk);
      run_op(8'h09, 8'd14, 8'd15, 8'd21, lat, e);
      peek(8'd21, rd); check("or_result", 32'(rd), 32'hAFF5);

      // illegal opcode
      host_wr(8'd7, 16'h1234);
      run_op(8'hFF, 8'd1, 8'd2, 8'd7, lat, e);
      check("illegal_latency", 32'(lat), 32'd4);
      check("illegal_err", 32'(e), 32'd1);
      check("illegal_ready", 32'(bus.ready), 32'd1);
      peek(8'd7, rd); check("illegal_no_write", 32'(rd), 32'h1234);

      // start and host_we while busy are dropped, then back-to-back start on done
      host_wr(8'd17, 16'h2222);
      host_wr(8'd20, 16'h1111);
      bus.start = 1'b1; bus.opcode = 8'h05; bus.src_a = 8'd1; bus.src_b = 8'd2; bus.dst = 8'd16;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      check("busy_ready_low", 32'(bus.ready), 32'd0);
      bus.start = 1'b1; bus.opcode = 8'h07; bus.dst = 8'd17;
      bus.host_we = 1'b1; bus.host_addr = 8'd20; bus.host_wdata = 16'hBEEF;
      @(negedge clk);
      bus.start = 1'b0; bus.host_we = 1'b0;
      check("busy_no_done_n3", 32'(bus.done), 32'd0);
      @(negedge clk);
      check("busy_no_done_n4", 32'(bus.done), 32'd0);
      @(negedge clk);
      check("busy_done_n5", 32'(bus.done), 32'd1);
      check("busy_done_ready", 32'(bus.ready), 32'd1);
      run_op(8'h07, 8'd2, 8'd1, 8'd18, lat, e);
      check("b2b_latency", 32'(lat), 32'd5);
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.done) extra++;
      end
      check("busy_start_not_queued", 32'(extra), 32'd0);
      peek(8'd16, rd); check("busy_first_result", 32'(rd), 32'h0007);
      peek(8'd17, rd); check("busy_dst_untouched", 32'(rd), 32'h2222);
      peek(8'd20, rd); check("busy_host_dropped", 32'(rd), 32'h1111);
      peek(8'd18, rd); check("b2b_result", 32'(rd), 32'h0001);

      // host write in the same cycle as start is seen by the operand reads
      host_wr(8'd12, 16'h0001);
      @(negedge clk);
      bus.host_we = 1'b1; bus.host_addr = 8'd12; bus.host_wdata = 16'h0010;
      run_op(8'h05, 8'd12, 8'd12, 8'd13, lat, e);
      peek(8'd13, rd); check("same_cycle_host_wr", 32'(rd), 32'h0020);

      // in-place operations
      host_wr(8'd8, 16'hA5A5);
      run_op(8'h0A, 8'd8, 8'd8, 8'd8, lat, e);
      peek(8'd8, rd); check("xor_in_place", 32'(rd), 32'h0000);
      host_wr(8'd10, 16'h0100);
      host_wr(8'd11, 16'h0023);
      run_op(8'h05, 8'd10, 8'd11, 8'd10, lat, e);
      peek(8'd10, rd); check("add_dst_eq_src_a", 32'(rd), 32'h0123);
      peek(8'd11, rd); check("add_src_b_same", 32'(rd), 32'h0023);

      // reset during EXEC
      host_wr(8'd9, 16'h5555);
      bus.start = 1'b1; bus.opcode = 8'h05; bus.src_a = 8'd1; bus.src_b = 8'd2; bus.dst = 8'd9;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      check("pre_reset_busy", 32'(bus.ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check("reset_mid_ready", 32'(bus.ready), 32'd1);
      check("reset_mid_done", 32'(bus.done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      extra = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.done) extra++;
      end
      check("reset_mid_no_done", 32'(extra), 32'd0);
      peek(8'd9, rd); check("reset_mid_mem_kept", 32'(rd), 32'h5555);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
